operand_issue_ctrl: RTL and testbench
=====================================

// Module: operand_issue_ctrl
// PURPOSE
//  Requester/writer side of the 64x32 register file. Accepts decoded instructions and tracks pending
//  destination writes in a busy-bit scoreboard. Stalls on RAW/WAW hazards, drives the regfile read
//  ports and registers operands into a one-entry EX stage register. Funnels writeback completions
//  onto the regfile write port, with same-cycle bypass.
// PARAMETERS
//  NREG  64  number of architectural registers (all writable, no hardwired zero)
//  AW    6   register index width (log2 NREG)
//  DW    32  data width
//  CNTW  16  hazard-stall counter width
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  rst              in   1   asynchronous, active-high reset
//  in_issue_valid   in   1   decoded instruction present
//  out_issue_ready  out  1   instruction accepted this cycle when valid&ready
//  in_rs / in_rt    in   AW  source register indices
//  in_rd            in   AW  destination register index
//  in_ctrl_regwrt   in   1   instruction will write in_rd
//  out_rf_rs/rt     out  AW  regfile read addresses (= in_rs/in_rt, combinational)
//  in_rf_rsval/rtval in  DW  regfile read data (combinational from regfile)
//  in_wb_valid      in   1   writeback completion this cycle
//  in_wb_rd         in   AW  writeback destination
//  in_wb_val        in   DW  writeback data
//  out_rf_regwrt    out  1   regfile write enable (= in_wb_valid)
//  out_rf_rd        out  AW  regfile write index (= in_wb_rd)
//  out_rf_rdval     out  DW  regfile write data (= in_wb_val)
//  out_ex_valid     out  1   EX stage register holds an instruction
//  in_ex_ready      in   1   EX consumes out_ex_* when valid&ready
//  out_ex_rsval/rtval out DW operand values
//  out_ex_rd        out  AW  destination index
//  out_ex_regwrt    out  1   destination write flag
//  out_err          out  1   sticky: writeback to a register not marked busy
//  out_stall_cnt    out  CNTW saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset: busy[] = 0, out_ex_valid = 0, out_ex_* data = 0, out_err = 0, out_stall_cnt = 0.
//  - Reset mid-operation drops all pending busy bits and any in-flight EX entry.
//  wb_hit(r) = in_wb_valid & (in_wb_rd == r).
//  Hazard conditions:
//  - RAW: (busy[rs] & !wb_hit(rs)) | (busy[rt] & !wb_hit(rt)).
//  - WAW: in_ctrl_regwrt & busy[rd] & !wb_hit(rd).
//  slot_free = !out_ex_valid | in_ex_ready.
//  out_issue_ready = slot_free & !hazard. It is combinational and may depend on in_issue_valid fields.
//  On accept, at the next edge:
//  - out_ex_valid = 1.
//  - rsval = wb_hit(rs) ? in_wb_val : in_rf_rsval; rtval likewise.
//  - out_ex_rd and out_ex_regwrt are latched.
//  - busy[rd] is set when in_ctrl_regwrt.
//  No accept & in_ex_ready: out_ex_valid goes to 0 and the data regs hold.
//  Back-to-back: one accept per cycle. Latency is 1 cycle from accept to out_ex_valid.
//  Writeback: in_wb_valid clears busy[in_wb_rd] at the edge and is forwarded to the regfile the
//  same cycle, unconditionally.
//  - If busy[in_wb_rd] == 0, the write still occurs and out_err is set (sticky until rst).
//  - Same-cycle set and clear of the same index (accept with regwrt rd == in_wb_rd): set wins,
//    so the bit stays busy.
//  Stall counter: increments when in_issue_valid & slot_free & hazard; saturates at 2^CNTW-1, no wrap.
//  - Backpressure-only stalls (!slot_free) are not counted.
//  rs == rt and rs == rd are legal; a self-dependency is judged against pre-accept busy state.
// STRUCTURE
//  Shared package: NREG, AW, DW constants; reg index and data typedefs.
//  Sub-module reg_scoreboard: NREG busy bits, set/clear ports, set-wins priority, 3 lookup ports.
//  Top level holds the hazard logic, the EX register, the bypass muxes, the error flag and the counter.
// TESTING
//  1. rst, issue rs=1 rt=2 rd=3 regwrt, regfile r1=8 r2=0x100
//     -> next cycle out_ex_valid=1, rsval=8, rtval=0x100, busy[3]=1.
//  2. Issue rs=3 while busy[3] and no wb -> ready=0, stall_cnt +1/cycle.
//     wb rd=3 val=0x55 -> accepted that cycle, rsval=0x55 (bypass), busy[3] cleared.
//  3. in_ex_ready=0 with out_ex_valid=1 -> ready=0, out_ex_* stable, stall_cnt unchanged.
//     Raise in_ex_ready -> next instruction is accepted.
//  4. wb rd=9 while busy[9]=0 -> regfile write enable pulses and out_err=1, held until rst.
//  5. Accept regwrt rd=5 in the same cycle as wb rd=5 (busy[5] was set) -> busy[5] stays 1.
//  6. Assert rst while busy bits are set and out_ex_valid=1 -> all outputs go to their reset values
//     immediately (async); force stall_cnt to saturation -> it holds at 0xFFFF.

Source files
------------

// File: rtl/operand_issue_ctrl_pkg.sv
// Shared constants and types for the operand issue controller and its scoreboard.
package operand_issue_ctrl_pkg;

    localparam int unsigned NREG     = 64;
    localparam int unsigned AW       = 6;
    localparam int unsigned DW       = 32;
    localparam int unsigned CNTW_DEF = 16;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;

    typedef struct packed {
        logic     valid;
        logic     regwrt;
        reg_idx_t rd;
        data_t    rsval;
        data_t    rtval;
    } ex_entry_t;

    localparam int unsigned NLOOKUP = 3;
    localparam int unsigned LK_RS   = 0;
    localparam int unsigned LK_RT   = 1;
    localparam int unsigned LK_RD   = 2;

endpackage

// File: rtl/operand_issue_ctrl_reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set-wins when set and clear hit the same index.
module reg_scoreboard
    import operand_issue_ctrl_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set_i,
    input  reg_idx_t                        set_idx_i,
    input  logic                            clr_i,
    input  reg_idx_t                        clr_idx_i,
    input  logic [NLOOKUP-1:0][AW-1:0]      lk_idx_i,
    output logic [NLOOKUP-1:0]              lk_busy_o,
    output logic                            clr_busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar g = 0; g < NLOOKUP; g++) begin : g_lk
        assign lk_busy_o[g] = busy_q[lk_idx_i[g]];
    end

    // Pre-edge busy state of the writeback target, used for the error flag
    assign clr_busy_o = busy_q[clr_idx_i];

endmodule

// File: rtl/operand_issue_ctrl.sv
// Issue side of the register file: hazard stall, operand read/bypass, EX stage register, writeback funnel.
module operand_issue_ctrl
    import operand_issue_ctrl_pkg::*;
#(
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_issue_valid,
    output logic            out_issue_ready,
    input  reg_idx_t        in_rs,
    input  reg_idx_t        in_rt,
    input  reg_idx_t        in_rd,
    input  logic            in_ctrl_regwrt,
    output reg_idx_t        out_rf_rs,
    output reg_idx_t        out_rf_rt,
    input  data_t           in_rf_rsval,
    input  data_t           in_rf_rtval,
    input  logic            in_wb_valid,
    input  reg_idx_t        in_wb_rd,
    input  data_t           in_wb_val,
    output logic            out_rf_regwrt,
    output reg_idx_t        out_rf_rd,
    output data_t           out_rf_rdval,
    output logic            out_ex_valid,
    input  logic            in_ex_ready,
    output data_t           out_ex_rsval,
    output data_t           out_ex_rtval,
    output reg_idx_t        out_ex_rd,
    output logic            out_ex_regwrt,
    output logic            out_err,
    output logic [CNTW-1:0] out_stall_cnt
);

    logic [NLOOKUP-1:0][AW-1:0] lk_idx;
    logic [NLOOKUP-1:0]         lk_busy;
    logic                       wb_busy;
    logic                       hit_rs, hit_rt, hit_rd;
    logic                       raw, waw, hazard, slot_free, accept;

    ex_entry_t       ex_q, ex_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    assign lk_idx[LK_RS] = in_rs;
    assign lk_idx[LK_RT] = in_rt;
    assign lk_idx[LK_RD] = in_rd;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (accept & in_ctrl_regwrt),
        .set_idx_i  (in_rd),
        .clr_i      (in_wb_valid),
        .clr_idx_i  (in_wb_rd),
        .lk_idx_i   (lk_idx),
        .lk_busy_o  (lk_busy),
        .clr_busy_o (wb_busy)
    );

    // A writeback landing this cycle resolves the hazard and feeds the operand directly
    assign hit_rs = in_wb_valid & (in_wb_rd == in_rs);
    assign hit_rt = in_wb_valid & (in_wb_rd == in_rt);
    assign hit_rd = in_wb_valid & (in_wb_rd == in_rd);

    assign raw       = (lk_busy[LK_RS] & ~hit_rs) | (lk_busy[LK_RT] & ~hit_rt);
    assign waw       = in_ctrl_regwrt & lk_busy[LK_RD] & ~hit_rd;
    assign hazard    = raw | waw;
    assign slot_free = ~ex_q.valid | in_ex_ready;
    assign accept    = in_issue_valid & slot_free & ~hazard;

    always_comb begin
        ex_d = ex_q;
        if (accept) begin
            ex_d.valid  = 1'b1;
            ex_d.regwrt = in_ctrl_regwrt;
            ex_d.rd     = in_rd;
            ex_d.rsval  = hit_rs ? in_wb_val : in_rf_rsval;
            ex_d.rtval  = hit_rt ? in_wb_val : in_rf_rtval;
        end else if (in_ex_ready) begin
            ex_d.valid = 1'b0;
        end
    end

    always_comb begin
        err_d       = err_q | (in_wb_valid & ~wb_busy);
        stall_cnt_d = stall_cnt_q;
        // Only hazard stalls with a free slot count; backpressure is EX's problem
        if (in_issue_valid & slot_free & hazard & (stall_cnt_q != {CNTW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_issue_ready = slot_free & ~hazard;
    assign out_rf_rs       = in_rs;
    assign out_rf_rt       = in_rt;
    assign out_rf_regwrt   = in_wb_valid;
    assign out_rf_rd       = in_wb_rd;
    assign out_rf_rdval    = in_wb_val;
    assign out_ex_valid    = ex_q.valid;
    assign out_ex_rsval    = ex_q.rsval;
    assign out_ex_rtval    = ex_q.rtval;
    assign out_ex_rd       = ex_q.rd;
    assign out_ex_regwrt   = ex_q.regwrt;
    assign out_err         = err_q;
    assign out_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Bench for operand_issue_ctrl: readiness table, hand-written corner sequences, random run vs reference model.
module tb_operand_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_issue_valid, out_issue_ready;
    logic [5:0]  in_rs, in_rt, in_rd;
    logic        in_ctrl_regwrt;
    logic [5:0]  out_rf_rs, out_rf_rt;
    logic [31:0] in_rf_rsval, in_rf_rtval;
    logic        in_wb_valid;
    logic [5:0]  in_wb_rd;
    logic [31:0] in_wb_val;
    logic        out_rf_regwrt;
    logic [5:0]  out_rf_rd;
    logic [31:0] out_rf_rdval;
    logic        out_ex_valid, in_ex_ready;
    logic [31:0] out_ex_rsval, out_ex_rtval;
    logic [5:0]  out_ex_rd;
    logic        out_ex_regwrt, out_err;
    logic [15:0] out_stall_cnt;

    always #5 clk = ~clk;

    operand_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_issue_valid(in_issue_valid), .out_issue_ready(out_issue_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl_regwrt(in_ctrl_regwrt),
        .out_rf_rs(out_rf_rs), .out_rf_rt(out_rf_rt),
        .in_rf_rsval(in_rf_rsval), .in_rf_rtval(in_rf_rtval),
        .in_wb_valid(in_wb_valid), .in_wb_rd(in_wb_rd), .in_wb_val(in_wb_val),
        .out_rf_regwrt(out_rf_regwrt), .out_rf_rd(out_rf_rd), .out_rf_rdval(out_rf_rdval),
        .out_ex_valid(out_ex_valid), .in_ex_ready(in_ex_ready),
        .out_ex_rsval(out_ex_rsval), .out_ex_rtval(out_ex_rtval),
        .out_ex_rd(out_ex_rd), .out_ex_regwrt(out_ex_regwrt),
        .out_err(out_err), .out_stall_cnt(out_stall_cnt)
    );

    // Register file contents, owned by the bench
    logic [31:0] rf [64];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                rf[i] <= (i == 1) ? 32'd8 : (i == 2) ? 32'h100 : 32'h0101_0101 * i + 32'd7;
        end else if (in_wb_valid) begin
            rf[in_wb_rd] <= in_wb_val;
        end
    end
    assign in_rf_rsval = rf[in_rs];
    assign in_rf_rtval = rf[in_rt];

    // Reference model: set of pending destinations plus a one-deep EX slot
    bit          busy_m [64];
    logic        exv_m, exwr_m, err_m;
    logic [31:0] exrs_m, exrt_m;
    logic [5:0]  exrd_m;
    int          cnt_m;

    function automatic bit hit(input logic [5:0] r);
        return in_wb_valid && (in_wb_rd == r);
    endfunction

    function automatic bit m_hazard();
        bit raw_h, waw_h;
        raw_h = (busy_m[in_rs] && !hit(in_rs)) || (busy_m[in_rt] && !hit(in_rt));
        waw_h = in_ctrl_regwrt && busy_m[in_rd] && !hit(in_rd);
        return raw_h || waw_h;
    endfunction

    function automatic bit m_slot();
        return !exv_m || in_ex_ready;
    endfunction

    function automatic bit m_ready();
        return m_slot() && !m_hazard();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) busy_m[i] <= 1'b0;
            exv_m <= 1'b0; exwr_m <= 1'b0; err_m <= 1'b0;
            exrs_m <= '0; exrt_m <= '0; exrd_m <= '0; cnt_m <= 0;
        end else begin
            if (in_issue_valid && m_ready()) begin
                exv_m  <= 1'b1;
                exrs_m <= hit(in_rs) ? in_wb_val : rf[in_rs];
                exrt_m <= hit(in_rt) ? in_wb_val : rf[in_rt];
                exrd_m <= in_rd;
                exwr_m <= in_ctrl_regwrt;
            end else if (in_ex_ready) begin
                exv_m <= 1'b0;
            end
            if (in_wb_valid) begin
                if (!busy_m[in_wb_rd]) err_m <= 1'b1;
                busy_m[in_wb_rd] <= 1'b0;
            end
            if (in_issue_valid && m_ready() && in_ctrl_regwrt) busy_m[in_rd] <= 1'b1;
            if (in_issue_valid && m_slot() && m_hazard() && cnt_m < 65535) cnt_m <= cnt_m + 1;
        end
    end

    int ncheck = 0;
    int nerr   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model at the falling edge, then advance one cycle
    task automatic tick();
        @(negedge clk);
        chk("ready", out_issue_ready, m_ready());
        chk("ex_valid", out_ex_valid, exv_m);
        chk("ex_rsval", out_ex_rsval, exrs_m);
        chk("ex_rtval", out_ex_rtval, exrt_m);
        chk("ex_rd", out_ex_rd, exrd_m);
        chk("ex_regwrt", out_ex_regwrt, exwr_m);
        chk("err", out_err, err_m);
        chk("stall_cnt", out_stall_cnt, cnt_m);
        chk("rf_rs", out_rf_rs, in_rs);
        chk("rf_rt", out_rf_rt, in_rt);
        chk("rf_regwrt", out_rf_regwrt, in_wb_valid);
        chk("rf_rd", out_rf_rd, in_wb_rd);
        chk("rf_rdval", out_rf_rdval, in_wb_val);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input int rs, input int rt, input int rd, input bit wr);
        in_issue_valid = v;
        in_rs = 6'(rs); in_rt = 6'(rt); in_rd = 6'(rd); in_ctrl_regwrt = wr;
    endtask

    task automatic wb(input bit v, input int rd, input logic [31:0] val);
        in_wb_valid = v; in_wb_rd = 6'(rd); in_wb_val = val;
    endtask

    typedef struct {
        int rs, rt, rd;
        bit wr, wbv;
        int wbrd;
        bit exr;
        bit exp_ready;
    } vec_t;

    vec_t vt [9];
    logic [31:0] sv_rs;
    logic [15:0] c0;

    initial begin
        // Readiness table; state when applied: busy={3}, EX slot occupied
        vt[0] = '{1, 2, 4, 1, 0, 0, 1, 1};
        vt[1] = '{3, 2, 4, 1, 0, 0, 1, 0};
        vt[2] = '{1, 3, 4, 1, 0, 0, 1, 0};
        vt[3] = '{1, 2, 3, 1, 0, 0, 1, 0};
        vt[4] = '{1, 2, 3, 0, 0, 0, 1, 1};
        vt[5] = '{3, 3, 3, 1, 1, 3, 1, 1};
        vt[6] = '{3, 2, 4, 0, 1, 4, 1, 0};
        vt[7] = '{1, 2, 4, 0, 0, 0, 0, 0};
        vt[8] = '{0, 0, 0, 0, 1, 7, 1, 1};

        rst = 1'b1;
        issue(0, 0, 0, 0, 0);
        wb(0, 0, 0);
        in_ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", out_ex_valid, 0);
        chk("rst_ex_rsval", out_ex_rsval, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", out_stall_cnt, 0);
        rst = 1'b0;
        tick();

        // Basic issue with operand read
        issue(1, 1, 2, 3, 1);
        tick();
        chk("t1_ex_valid", out_ex_valid, 1);
        chk("t1_rsval", out_ex_rsval, 32'd8);
        chk("t1_rtval", out_ex_rtval, 32'h100);
        chk("t1_rd", out_ex_rd, 3);

        issue(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            issue(0, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].wr);
            wb(vt[i].wbv, vt[i].wbrd, 32'h0);
            in_ex_ready = vt[i].exr;
            #1;
            chk($sformatf("vec%0d_ready", i), out_issue_ready, vt[i].exp_ready);
        end
        wb(0, 0, 0);
        in_ex_ready = 1'b1;

        // RAW stall counts per cycle, resolved by a bypassing writeback
        issue(1, 3, 0, 10, 0);
        #1;
        chk("t2_ready_stall", out_issue_ready, 0);
        c0 = out_stall_cnt;
        repeat (3) tick();
        chk("t2_cnt", out_stall_cnt, c0 + 16'd3);
        wb(1, 3, 32'h55);
        #1;
        chk("t2_ready_bypass", out_issue_ready, 1);
        tick();
        chk("t2_rsval_bypass", out_ex_rsval, 32'h55);
        wb(0, 0, 0);
        issue(0, 3, 0, 10, 0);
        #1;
        chk("t2_busy3_clear", out_issue_ready, 1);

        // Backpressure holds EX and is not counted
        in_ex_ready = 1'b0;
        issue(1, 1, 2, 11, 0);
        #1;
        chk("t3_ready_bp", out_issue_ready, 0);
        sv_rs = out_ex_rsval;
        c0 = out_stall_cnt;
        repeat (2) tick();
        chk("t3_ex_hold_valid", out_ex_valid, 1);
        chk("t3_ex_hold_rs", out_ex_rsval, sv_rs);
        chk("t3_cnt_hold", out_stall_cnt, c0);
        in_ex_ready = 1'b1;
        #1;
        chk("t3_ready_release", out_issue_ready, 1);
        tick();
        chk("t3_new_rd", out_ex_rd, 11);
        chk("t3_new_rs", out_ex_rsval, 32'd8);
        issue(0, 0, 0, 0, 0);
        tick();
        chk("t3_drain", out_ex_valid, 0);

        // Writeback to an idle register
        wb(1, 9, 32'h99);
        #1;
        chk("t4_rf_we", out_rf_regwrt, 1);
        chk("t4_rf_rd", out_rf_rd, 9);
        tick();
        chk("t4_err", out_err, 1);
        wb(0, 0, 0);
        repeat (3) tick();
        chk("t4_err_sticky", out_err, 1);

        // Same-cycle set and clear of one index: set wins
        issue(1, 0, 0, 5, 1);
        tick();
        issue(1, 0, 0, 5, 1);
        wb(1, 5, 32'h5a5a);
        #1;
        chk("t5_ready", out_issue_ready, 1);
        tick();
        wb(0, 0, 0);
        issue(0, 5, 0, 0, 0);
        #1;
        chk("t5_busy5_kept", out_issue_ready, 0);
        wb(1, 5, 32'h1);
        tick();
        wb(0, 0, 0);

        // Random traffic over a small register window so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            issue($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1));
            wb($urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom);
            in_ex_ready = $urandom_range(0, 9) < 7;
            tick();
        end

        // Asynchronous reset mid-operation
        wb(0, 0, 0);
        in_ex_ready = 1'b1;
        issue(1, 0, 0, 5, 1);
        tick();
        issue(1, 0, 0, 6, 1);
        tick();
        issue(0, 5, 6, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ex_valid", out_ex_valid, 0);
        chk("t6_ex_rsval", out_ex_rsval, 0);
        chk("t6_err", out_err, 0);
        chk("t6_cnt", out_stall_cnt, 0);
        chk("t6_busy_dropped", out_issue_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Drive the stall counter into saturation
        issue(1, 0, 0, 1, 1);
        tick();
        issue(1, 1, 0, 12, 0);
        repeat (65540) tick();
        chk("t6_cnt_sat", out_stall_cnt, 16'hFFFF);
        tick();
        chk("t6_cnt_sat_hold", out_stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
        $finish;
    end

endmodule
